seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector; successor to the fixed 4-bit detector.
- Pattern length up to MAX_LEN bits, overlapping or non-overlapping mode, input-valid qualifier, saturating match counter.
- Sits on a serial bit stream (framing/sync-word search); match pulse feeds downstream control logic.

---
 rtl/seq_detector_prog.sv | 133 +++++++++++++
 tb/tb_seq_detector_prog.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial bit-pattern detector
// Pattern/length/overlap are loaded at runtime; match pulse plus saturating count.

module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0000_1101,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               o,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat,
    output logic               cfg_err,
    output logic [1:0]         state_o
);

    localparam int FW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        FILL = 2'b00,
        HUNT = 2'b01,
        HOLD = 2'b10,
        BAD  = 2'b11
    } state_t;

    function automatic logic [MAX_LEN-1:0] len_mask(input int n);
        logic [MAX_LEN-1:0] m;
        for (int k = 0; k < MAX_LEN; k++) m[k] = (k < n);
        return m;
    endfunction

    localparam logic [MAX_LEN-1:0] DEF_PAT = DEF_PATTERN & len_mask(DEF_LEN);

    state_t             state, state_n;
    logic [MAX_LEN-1:0] hist, hist_n, hist_sh;
    logic [FW-1:0]      fill, fill_n, fill_inc;
    logic [MAX_LEN-1:0] pat, pat_n;
    logic [LEN_W-1:0]   len, len_n;
    logic               ovl, ovl_n;
    logic               o_n, err_n, hit, len_ok;
    logic [CNT_W-1:0]   cnt_n;

    always_comb begin
        len_ok   = cfg_load && (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
        hist_sh  = {hist[MAX_LEN-2:0], i};
        fill_inc = (int'(fill) >= MAX_LEN) ? fill : fill + FW'(1);
        hit      = (int'(fill_inc) >= int'(len)) &&
                   (((hist_sh ^ pat) & len_mask(int'(len))) == '0);

        state_n = state;
        hist_n  = hist;
        fill_n  = fill;
        pat_n   = pat;
        len_n   = len;
        ovl_n   = ovl;
        o_n     = 1'b0;
        err_n   = cfg_load && !len_ok;

        if (state == BAD) begin
            state_n = FILL;
            fill_n  = '0;
        end else if (len_ok) begin
            // Legal reconfiguration wins over a same-edge data bit.
            pat_n   = cfg_pattern & len_mask(int'(cfg_len));
            len_n   = cfg_len;
            ovl_n   = cfg_overlap;
            hist_n  = '0;
            fill_n  = '0;
            state_n = FILL;
        end else if (in_valid) begin
            hist_n = hist_sh;
            fill_n = fill_inc;
            o_n    = hit;
            if (hit && !ovl) begin
                state_n = HOLD;
                fill_n  = '0;
            end else if (int'(fill_inc) >= int'(len)) begin
                state_n = HUNT;
            end else begin
                state_n = FILL;
            end
        end else if (state == HOLD) begin
            state_n = FILL;
        end

        cnt_n = match_count;
        if (o_n) begin
            if (cnt_clr)      cnt_n = CNT_W'(1);
            else if (!cnt_sat) cnt_n = match_count + CNT_W'(1);
        end else if (cnt_clr) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            hist        <= '0;
            fill        <= '0;
            pat         <= DEF_PAT;
            len         <= LEN_W'(DEF_LEN);
            ovl         <= DEF_OVERLAP;
            o           <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            hist        <= hist_n;
            fill        <= fill_n;
            pat         <= pat_n;
            len         <= len_n;
            ovl         <= ovl_n;
            o           <= o_n;
            match_count <= cnt_n;
            cfg_err     <= err_n;
        end
    end

    assign cnt_sat = &match_count;
    assign state_o = state;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - directed vector bench for seq_detector_prog
// Second instance with CNT_W=2 shares all inputs to exercise counter saturation.

module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i = 1'b0;
    logic       in_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       o, cnt_sat, cfg_err;
    logic [7:0] match_count;
    logic [1:0] state_o;
    logic       o2, sat2, err2;
    logic [1:0] cnt2, st2;

    int total = 0;
    int passed = 0;

    seq_detector_prog dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .o(o), .match_count(match_count), .cnt_sat(cnt_sat),
        .cfg_err(cfg_err), .state_o(state_o)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .o(o2), .match_count(cnt2), .cnt_sat(sat2),
        .cfg_err(err2), .state_o(st2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       clr;
        logic       v;
        logic       b;
        logic       eo;
        logic [1:0] es;
        logic       ee;
        int         ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic row(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr, input logic v, input logic b,
                       input logic eo, input logic [1:0] es, input logic ee, input int ecnt);
        vec_t r;
        r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl; r.clr = clr;
        r.v = v; r.b = b; r.eo = eo; r.es = es; r.ee = ee; r.ecnt = ecnt;
        tbl.push_back(r);
    endtask

    task automatic br(input logic v, input logic b, input logic eo,
                      input logic [1:0] es, input int ecnt);
        row(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, v, b, eo, es, 1'b0, ecnt);
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        in_valid = v; i = b; cnt_clr = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        logic [3:0] p4;
        logic [6:0] post;
        p4   = 4'b1101;
        post = 7'b1011101;

        // Defaults, overlap: 1101101 -> matches after bits 4 and 7
        br(1,1,0,0,-1); br(1,1,0,0,-1); br(1,0,0,0,-1); br(1,1,1,1,1);
        br(1,1,0,1,-1); br(1,0,0,1,-1); br(1,1,1,1,2);
        // Non-overlap 1101: 0 1101101 -> one match, HUNT -> HOLD -> FILL
        row(1,8'h0D,4,0,0,0,0,0,0,0,2);
        br(1,0,0,0,-1); br(1,1,0,0,-1); br(1,1,0,0,-1); br(1,0,0,1,-1);
        br(1,1,1,2,3);  br(1,1,0,0,-1); br(1,0,0,0,-1); br(1,1,0,0,3);
        // 8-bit pattern with a 3-cycle valid gap
        row(1,8'hB3,8,1,0,0,0,0,0,0,3);
        br(1,0,0,0,-1); br(1,1,0,0,-1); br(1,0,0,0,-1); br(1,1,0,0,-1); br(1,1,0,0,-1);
        br(0,1,0,0,-1); br(0,1,0,0,-1); br(0,1,0,0,-1);
        br(1,0,0,0,-1); br(1,0,0,0,-1); br(1,1,0,1,-1); br(1,1,1,1,4);
        // Upper pattern bits ignored; illegal lengths flag cfg_err only
        row(1,8'hFD,4,1,0,0,0,0,0,0,4);
        row(1,8'hFF,0,0,0,0,0,0,0,1,4);
        row(1,8'hFF,9,0,0,1,1,0,0,1,-1);
        br(1,1,0,0,-1); br(1,0,0,0,-1); br(1,1,1,1,5);
        // cfg_load mid-pattern discards the same-edge bit and history
        br(1,1,0,1,-1); br(1,1,0,1,-1); br(1,0,0,1,5);
        row(1,8'h0D,4,1,0,1,1,0,0,0,5);
        br(1,1,0,0,-1); br(1,0,0,0,-1); br(1,1,0,0,-1);
        br(1,1,0,1,-1); br(1,0,0,1,-1); br(1,1,1,1,6);
        // len=1 non-overlap: HOLD still accepts and matches a bit
        row(1,8'h01,1,0,0,0,0,0,0,0,6);
        br(1,1,1,2,7); br(1,1,1,2,8); br(1,0,0,1,8); br(1,1,1,2,9);
        br(0,0,0,0,9);
        row(1,8'h0D,4,1,1,0,0,0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset o", o, 0);
        check("reset count", match_count, 0);
        check("reset sat", cnt_sat, 0);
        check("reset err", cfg_err, 0);
        check("reset state", state_o, 0);
        rst = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            cfg_load = tbl[n].ld; cfg_pattern = tbl[n].pat; cfg_len = tbl[n].len;
            cfg_overlap = tbl[n].ovl;
            step(tbl[n].v, tbl[n].b, tbl[n].clr);
            cfg_load = 1'b0;
            check($sformatf("vec%0d o", n), o, tbl[n].eo);
            check($sformatf("vec%0d state", n), state_o, tbl[n].es);
            check($sformatf("vec%0d cfg_err", n), cfg_err, tbl[n].ee);
            if (tbl[n].ecnt >= 0)
                check($sformatf("vec%0d count", n), match_count, tbl[n].ecnt);
        end

        // Saturation on the 2-bit counter: 1101 x5 with overlap
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, p4[3 - ((n - 1) % 4)], 1'b0);
            check($sformatf("sat stream bit%0d o", n), o, (n % 4 == 0) ? 1 : 0);
            if (n == 12) begin
                check("cnt2 at 3 matches", cnt2, 3);
                check("sat2 at 3 matches", sat2, 1);
                check("cnt at 3 matches", match_count, 3);
            end
        end
        check("cnt after 5 matches", match_count, 5);
        check("cnt2 held at 3", cnt2, 3);
        check("sat2 held", sat2, 1);
        for (int n = 0; n < 4; n++) step(1'b1, p4[3 - n], (n == 3));
        check("clr on match o", o, 1);
        check("clr on match cnt", match_count, 1);
        check("clr on match cnt2", cnt2, 1);
        check("clr on match sat2", sat2, 0);

        // Async reset mid-stream reverts config and drops history
        cfg_load = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        cfg_load = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre-reset o", o, 1);
        check("pre-reset state", state_o, 2);
        #2 rst = 1'b1;
        #1;
        check("async rst o", o, 0);
        check("async rst count", match_count, 0);
        check("async rst cnt2", cnt2, 0);
        check("async rst state", state_o, 0);
        #1 rst = 1'b0;
        for (int n = 0; n < 7; n++) begin
            step(1'b1, post[6 - n], 1'b0);
            check($sformatf("post-reset bit%0d o", n), o, (n == 6) ? 1 : 0);
        end
        check("post-reset count", match_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
